// File: rtl/phv_pkg.sv
// Shared PHV definitions used by the assembler, the elastic buffer and the parser.
package phv_pkg;

    localparam int unsigned PHV_DATA_W = 480;
    localparam int unsigned PHV_CTRL_W = 32;
    localparam int unsigned PHV_DROP_W = 16;

    // ctl in the upper bits so a packed word matches the {ctl,data} storage layout
    typedef struct packed {
        logic [PHV_CTRL_W-1:0] ctl;
        logic [PHV_DATA_W-1:0] data;
    } phv_word_t;

endpackage

// File: rtl/phv_buffer_if.sv
// Assembler-to-buffer write strobe and buffer-to-parser valid/ready handshake.
interface phv_buffer_if
    import phv_pkg::*;
#(
    parameter int unsigned CTRL_WIDTH = PHV_CTRL_W,
    parameter int unsigned DATA_WIDTH = PHV_DATA_W
) ();

    logic                  in_wr;
    logic [CTRL_WIDTH-1:0] in_ctl;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [CTRL_WIDTH-1:0] out_ctl;
    logic [DATA_WIDTH-1:0] out_data;

    // environment side: assembler producing words, parser consuming them
    modport master (
        output in_wr, in_ctl, in_data, out_ready,
        input  out_valid, out_ctl, out_data
    );

    // buffer side
    modport slave (
        input  in_wr, in_ctl, in_data, out_ready,
        output out_valid, out_ctl, out_data
    );

endinterface

// File: rtl/phv_fifo_mem.sv
// Unreset FIFO storage: one synchronous write port, one asynchronous read port.
module phv_fifo_mem #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [WIDTH-1:0]      rdata_c
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_c = mem[raddr];

endmodule

// File: rtl/phv_buffer.sv
// Elastic FWFT buffer between the packet assembler and the parser; full-time writes are dropped.
// Optional drop counter enabled by defining PHV_DROP_CNT_EN.
module phv_buffer
    import phv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = PHV_DATA_W,
    parameter int unsigned CTRL_WIDTH = PHV_CTRL_W,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    phv_buffer_if.slave           bus,
`ifdef PHV_DROP_CNT_EN
    input  logic                  drop_clr,
    output logic [PHV_DROP_W-1:0] drop_cnt,
`endif
    output logic                  full
);

    localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);
    localparam int unsigned CNT_WIDTH  = ADDR_WIDTH + 1;
    localparam int unsigned WORD_WIDTH = CTRL_WIDTH + DATA_WIDTH;

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [CNT_WIDTH-1:0]  count;
    logic [CNT_WIDTH-1:0]  count_nxt;
    logic                  valid;
    logic                  push_c;
    logic                  pop_c;
    logic                  drop_c;
    logic [WORD_WIDTH-1:0] head_c;

    // a pop frees the slot the simultaneous push needs, so full+push+pop is accepted
    always_comb begin
        pop_c     = valid && bus.out_ready;
        push_c    = bus.in_wr && (!full || pop_c);
        drop_c    = bus.in_wr && full && !pop_c;
        count_nxt = count;
        if (push_c && !pop_c) begin
            count_nxt = count + CNT_WIDTH'(1);
        end else if (pop_c && !push_c) begin
            count_nxt = count - CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= 1'b0;
            full   <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
            count <= count_nxt;
            valid <= (count_nxt != '0);
            full  <= (count_nxt == CNT_WIDTH'(DEPTH));
        end
    end

`ifdef PHV_DROP_CNT_EN
    // clear wins over the old value but still counts a drop in the same cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            drop_cnt <= '0;
        end else if (drop_clr) begin
            drop_cnt <= drop_c ? PHV_DROP_W'(1) : '0;
        end else if (drop_c && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + PHV_DROP_W'(1);
        end
    end
`else
    logic unused_drop;
    assign unused_drop = drop_c;
`endif

    phv_fifo_mem #(
        .WIDTH      (WORD_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .we      (push_c && rst),
        .waddr   (wr_ptr),
        .wdata   ({bus.in_ctl, bus.in_data}),
        .raddr   (rd_ptr),
        .rdata_c (head_c)
    );

    assign bus.out_valid = valid;
    assign bus.out_ctl   = valid ? head_c[WORD_WIDTH-1 -: CTRL_WIDTH] : '0;
    assign bus.out_data  = valid ? head_c[DATA_WIDTH-1:0] : '0;

endmodule

// File: tb/tb_phv_buffer.sv
// Self-checking bench for phv_buffer: directed scenarios plus random traffic against a queue model.
module tb_phv_buffer;
    import phv_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic full;
    always #5 clk = ~clk;

    phv_buffer_if bus ();

`ifdef PHV_DROP_CNT_EN
    logic                  drop_clr = 1'b0;
    logic [PHV_DROP_W-1:0] drop_cnt;
    int unsigned           m_drop = 0;
`endif

    phv_buffer #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
`ifdef PHV_DROP_CNT_EN
        .drop_clr (drop_clr),
        .drop_cnt (drop_cnt),
`endif
        .full     (full)
    );

    phv_word_t q[$];
    int n_cmp = 0;
    int n_bad = 0;

    // model: a bounded in-order queue of words; one edge per call, outputs sampled 1ns later
    task automatic tick();
        bit pop, push, dropped;
        @(posedge clk);
        if (!rst) begin
            q.delete();
`ifdef PHV_DROP_CNT_EN
            m_drop = 0;
`endif
        end else begin
            pop     = (q.size() != 0) && bus.out_ready;
            push    = bus.in_wr && ((q.size() < DEPTH) || pop);
            dropped = bus.in_wr && !push;
            if (pop) void'(q.pop_front());
            if (push) q.push_back('{ctl: bus.in_ctl, data: bus.in_data});
`ifdef PHV_DROP_CNT_EN
            if (drop_clr) m_drop = dropped ? 1 : 0;
            else if (dropped && m_drop != 32'hFFFF) m_drop = m_drop + 1;
`else
            if (dropped) begin end
`endif
        end
        #1;
    endtask

    task automatic put(input logic wr, input logic [31:0] v);
        bus.in_wr   = wr;
        bus.in_ctl  = v ^ 32'hC0DE_0000;
        bus.in_data = PHV_DATA_W'(v);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        put(1'b1, 32'h55);
        repeat (3) tick();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
        n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL reset_full got=%b exp=0", full); end
        n_cmp++; if (bus.out_data !== '0) begin n_bad++; $display("FAIL reset_data got=%h exp=0", bus.out_data); end
`ifdef PHV_DROP_CNT_EN
        n_cmp++; if (drop_cnt !== '0) begin n_bad++; $display("FAIL reset_drop got=%0d exp=0", drop_cnt); end
`endif
        rst = 1'b1;
        put(1'b0, 0);
        tick();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_wr_ignored got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_single();
        logic [PHV_DATA_W-1:0] d;
        d = {60{8'hA5}};
        bus.in_wr = 1'b1; bus.in_ctl = 32'h0102_0304; bus.in_data = d;
        tick();
        bus.in_wr = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid got=%b exp=1", bus.out_valid); end
        n_cmp++; if (bus.out_ctl !== 32'h0102_0304) begin n_bad++; $display("FAIL single_ctl got=%h exp=01020304", bus.out_ctl); end
        n_cmp++; if (bus.out_data !== d) begin n_bad++; $display("FAIL single_data got=%h exp=%h", bus.out_data, d); end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL single_pop got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_fill_order();
        bus.out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin put(1'b1, 32'(k)); tick(); end
        put(1'b0, 0);
        n_cmp++; if (full !== 1'b1) begin n_bad++; $display("FAIL fill_full got=%b exp=1", full); end
        bus.out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            n_cmp++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== PHV_DATA_W'(k)) begin
                n_bad++; $display("FAIL fill_order_%0d got=%b/%0h exp=1/%0h", k, bus.out_valid, bus.out_data, k);
            end
            tick();
        end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL fill_empty got=%b exp=0", bus.out_valid); end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_overflow();
        int exp_seq[4] = '{2, 3, 4, 6};
        for (int k = 1; k <= 4; k++) begin put(1'b1, 32'(k)); tick(); end
        put(1'b1, 32'd5);
        tick();
        n_cmp++; if (bus.out_data !== PHV_DATA_W'(1)) begin n_bad++; $display("FAIL ovf_head got=%0h exp=1", bus.out_data); end
        n_cmp++; if (full !== 1'b1) begin n_bad++; $display("FAIL ovf_full got=%b exp=1", full); end
`ifdef PHV_DROP_CNT_EN
        n_cmp++; if (drop_cnt !== 16'd1) begin n_bad++; $display("FAIL ovf_drop1 got=%0d exp=1", drop_cnt); end
        tick();
        n_cmp++; if (drop_cnt !== 16'd2) begin n_bad++; $display("FAIL ovf_drop2 got=%0d exp=2", drop_cnt); end
        drop_clr = 1'b1;
        tick();
        n_cmp++; if (drop_cnt !== 16'd1) begin n_bad++; $display("FAIL ovf_clr_drop got=%0d exp=1", drop_cnt); end
        put(1'b0, 0);
        tick();
        drop_clr = 1'b0;
        n_cmp++; if (drop_cnt !== 16'd0) begin n_bad++; $display("FAIL ovf_clr got=%0d exp=0", drop_cnt); end
`endif
        put(1'b1, 32'd6);
        bus.out_ready = 1'b1;
        tick();
        put(1'b0, 0);
        n_cmp++; if (full !== 1'b1 || bus.out_data !== PHV_DATA_W'(2)) begin
            n_bad++; $display("FAIL ovf_pushpop got=%b/%0h exp=1/2", full, bus.out_data);
        end
`ifdef PHV_DROP_CNT_EN
        n_cmp++; if (drop_cnt !== 16'd0) begin n_bad++; $display("FAIL ovf_pushpop_drop got=%0d exp=0", drop_cnt); end
`endif
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== PHV_DATA_W'(exp_seq[k])) begin
                n_bad++; $display("FAIL ovf_drain_%0d got=%b/%0h exp=1/%0h", k, bus.out_valid, bus.out_data, exp_seq[k]);
            end
            tick();
        end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL ovf_empty got=%b exp=0", bus.out_valid); end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_wrap();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            put(1'b1, 32'(100 + k));
            tick();
            n_cmp++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== PHV_DATA_W'(100 + k) || full !== 1'b0) begin
                n_bad++; $display("FAIL wrap_%0d got=%b/%0h/%b exp=1/%0h/0", k, bus.out_valid, bus.out_data, full, 100 + k);
            end
        end
        put(1'b0, 0);
        tick();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL wrap_empty got=%b exp=0", bus.out_valid); end
`ifdef PHV_DROP_CNT_EN
        n_cmp++; if (drop_cnt !== 16'd0) begin n_bad++; $display("FAIL wrap_drop got=%0d exp=0", drop_cnt); end
`endif
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 3; k++) begin put(1'b1, 32'(8'h31 + k)); tick(); end
        put(1'b0, 0);
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL mid_pre got=%b exp=1", bus.out_valid); end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        n_cmp++; if (bus.out_valid !== 1'b0 || full !== 1'b0) begin
            n_bad++; $display("FAIL mid_reset got=%b/%b exp=0/0", bus.out_valid, full);
        end
        put(1'b1, 32'h77);
        tick();
        put(1'b0, 0);
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== PHV_DATA_W'(32'h77)) begin
            n_bad++; $display("FAIL mid_push got=%b/%0h exp=1/77", bus.out_valid, bus.out_data);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_alone got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_random();
        phv_word_t h;
        int unsigned rdy_pct;
        for (int c = 0; c < 600; c++) begin
            rdy_pct = ((c / 100) % 2 == 0) ? 30 : 80;
            bus.in_wr     = ($urandom_range(99) < 60);
            bus.in_ctl    = $urandom;
            bus.in_data   = {15{$urandom}};
            bus.out_ready = ($urandom_range(99) < rdy_pct);
            rst           = ($urandom_range(199) != 0);
`ifdef PHV_DROP_CNT_EN
            drop_clr      = ($urandom_range(99) < 4);
`endif
            tick();
            h = (q.size() != 0) ? q[0] : '0;
            n_cmp++; if (bus.out_valid !== (q.size() != 0)) begin
                n_bad++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, bus.out_valid, q.size() != 0);
            end
            n_cmp++; if (bus.out_ctl !== h.ctl) begin
                n_bad++; $display("FAIL rnd_ctl c=%0d got=%h exp=%h", c, bus.out_ctl, h.ctl);
            end
            n_cmp++; if (bus.out_data !== h.data) begin
                n_bad++; $display("FAIL rnd_data c=%0d got=%h exp=%h", c, bus.out_data, h.data);
            end
            n_cmp++; if (full !== (q.size() == DEPTH)) begin
                n_bad++; $display("FAIL rnd_full c=%0d got=%b exp=%b", c, full, q.size() == DEPTH);
            end
`ifdef PHV_DROP_CNT_EN
            n_cmp++; if (drop_cnt !== 16'(m_drop)) begin
                n_bad++; $display("FAIL rnd_drop c=%0d got=%0d exp=%0d", c, drop_cnt, m_drop);
            end
`endif
        end
        rst = 1'b1;
        put(1'b0, 0);
        bus.out_ready = 1'b0;
`ifdef PHV_DROP_CNT_EN
        drop_clr = 1'b0;
`endif
    endtask

    initial begin
        bus.in_wr     = 1'b0;
        bus.in_ctl    = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_single();
        test_fill_order();
        test_overflow();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
